// File: rtl/buzzer_tone_driver.sv
// Piezo square-wave driver fed by a one-hot note code, with an articulation gap on note changes.
// Optional macro PIEZO_DIFF_EN adds a complementary piezo_n pin for bridge drive.
module buzzer_tone_driver #(
  parameter int CLK_HZ     = 50000000,
  parameter int CNT_W      = 24,
  parameter int GAP_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [12:0] beat,
  input  logic        light,
  output logic        piezo,
  output logic        led,
  output logic        note_active,
  output logic [3:0]  cur_note,
  output logic        code_err
`ifdef PIEZO_DIFF_EN
  ,
  output logic        piezo_n
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_TONE
  } state_t;

  function automatic logic [CNT_W-1:0] half_of(input int freq);
    int h;
    h = CLK_HZ / (2 * freq);
    if (h < 1) h = 1;
    return CNT_W'(h);
  endfunction

  // Entries 13..15 are never selected; they only pad the table to the index width.
  localparam logic [CNT_W-1:0] HALF_TBL [16] = '{
    half_of(262), half_of(277), half_of(294), half_of(311),
    half_of(330), half_of(349), half_of(370), half_of(392),
    half_of(415), half_of(440), half_of(466), half_of(494),
    half_of(523), CNT_W'(1), CNT_W'(1), CNT_W'(1)
  };

  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  logic [12:0]      r_beat_q;
  logic             r_led;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_piezo;
  logic [3:0]       r_note;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_piezo_next;
  logic [3:0]       w_note_next;
  logic             w_valid;
  logic             w_invalid;
  logic [3:0]       w_idx;
  logic [CNT_W-1:0] w_half;

  assign w_valid   = (r_beat_q != '0) && ((r_beat_q & (r_beat_q - 13'd1)) == '0);
  assign w_invalid = (r_beat_q != '0) && !w_valid;
  assign w_half    = HALF_TBL[w_idx];

  always_comb begin
    w_idx = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (r_beat_q[i]) w_idx = 4'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_beat_q <= '0;
      r_led    <= 1'b0;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_piezo  <= 1'b0;
      r_note   <= 4'd0;
    end else begin
      r_beat_q <= beat;
      r_led    <= light;
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_piezo  <= w_piezo_next;
      r_note   <= w_note_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_piezo_next = r_piezo;
    w_note_next  = r_note;
    case (r_state)
      S_IDLE: begin
        w_piezo_next = 1'b0;
        if (w_valid) begin
          w_state_next = S_TONE;
          w_note_next  = w_idx;
          w_cnt_next   = w_half - CNT_W'(1);
          w_piezo_next = 1'b1;
        end
      end
      S_TONE: begin
        if (!w_valid) begin
          w_state_next = S_IDLE;
          w_piezo_next = 1'b0;
          w_cnt_next   = '0;
        end else if (w_idx == r_note) begin
          // Same note held: free-run so the phase is never disturbed.
          if (r_cnt == '0) begin
            w_piezo_next = ~r_piezo;
            w_cnt_next   = w_half - CNT_W'(1);
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end else if (GAP_CYCLES > 0) begin
          w_state_next = S_GAP;
          w_piezo_next = 1'b0;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_note_next  = w_idx;
          w_cnt_next   = w_half - CNT_W'(1);
          w_piezo_next = 1'b1;
        end
      end
      S_GAP: begin
        w_piezo_next = 1'b0;
        if (!w_valid) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == '0) begin
          // The gap ends on whatever note is present now, not the one that started it.
          w_state_next = S_TONE;
          w_note_next  = w_idx;
          w_cnt_next   = w_half - CNT_W'(1);
          w_piezo_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_piezo_next = 1'b0;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign piezo       = r_piezo;
  assign led         = r_led;
  assign note_active = (r_state == S_TONE);
  assign cur_note    = note_active ? r_note : 4'd0;
  assign code_err    = w_invalid;

`ifdef PIEZO_DIFF_EN
  assign piezo_n = note_active & ~r_piezo;
`endif

endmodule
